wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 119 +++++++++++
 tb/tb_wb_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter: pipeline priority, long-unit result queue, pending scoreboard
// Pipeline writes always win the single write port; long-unit results wait in a FIFO and drain on idle cycles.

module wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_waddr,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        busy1,
    output logic        busy2,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [4:0]  fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    logic [36:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          we_q, we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   pending_q, pending_d;

    logic          pipe_ok;
    logic          push;
    logic          pop;
    logic [36:0]   head;

    // Ready reflects occupancy only, so a full queue never accepts even while popping.
    assign lu_ready   = (count_q < DEPTH_C);
    assign fifo_count = count_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy1      = pending_q[raddr1];
    assign busy2      = pending_q[raddr2];

    always_comb begin
        pipe_ok   = pipe_we && (pipe_waddr != 5'd0);
        push      = lu_valid && lu_ready && (lu_waddr != 5'd0);
        pop       = !pipe_ok && (count_q != 5'd0);
        head      = mem_q[rd_ptr_q];

        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (pipe_ok) begin
            we_d    = 1'b1;
            waddr_d = pipe_waddr;
            wdata_d = pipe_wdata;
        end else if (pop) begin
            we_d    = 1'b1;
            waddr_d = head[36:32];
            wdata_d = head[31:0];
        end

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (!push && pop) begin
            count_d = count_q - 5'd1;
        end

        // Clear first so a same-edge reservation of the same register survives.
        pending_d = pending_q;
        if (we_d) begin
            pending_d[waddr_d] = 1'b0;
        end
        if (iss_valid && (iss_waddr != 5'd0)) begin
            pending_d[iss_waddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lu_waddr, lu_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.

module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .lu_ready   (lu_ready),
        .iss_valid  (iss_valid),
        .iss_waddr  (iss_waddr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        iss_valid = 1'b0; iss_waddr = '0;
        raddr1 = 5'd7; raddr2 = 5'd7;

        // Reset state
        tick(); tick();
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", lu_ready, 1);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;
        tick();

        // Single pipeline write, then hold on idle
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1234;
        tick();
        pipe_we = 1'b0;
        chk("pipe_we", we, 1);
        chk("pipe_waddr", waddr, 3);
        chk("pipe_wdata", wdata, 32'h1234);
        tick();
        chk("idle_we", we, 0);
        chk("idle_hold_waddr", waddr, 3);
        chk("idle_hold_wdata", wdata, 32'h1234);

        // Long-unit result waits behind four pipeline writes
        pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'd10;
        lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hAAAA;
        tick();
        lu_valid = 1'b0;
        chk("lu_q_count_n1", fifo_count, 1);
        chk("lu_q_waddr_n1", waddr, 10);
        for (int i = 1; i <= 3; i++) begin
            pipe_waddr = 5'(10 + i); pipe_wdata = 32'(10 + i);
            tick();
            chk("lu_q_count", fifo_count, 1);
            chk("lu_q_pipe_waddr", waddr, 32'(10 + i));
        end
        pipe_we = 1'b0;
        tick();
        chk("lu_out_we", we, 1);
        chk("lu_out_waddr", waddr, 5);
        chk("lu_out_wdata", wdata, 32'hAAAA);
        chk("lu_out_count", fifo_count, 0);
        tick();
        chk("lu_out_done", we, 0);

        // Fill the queue, hold the fifth, then drain in order
        pipe_we = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'd20;
        for (int i = 1; i <= 4; i++) begin
            lu_valid = 1'b1; lu_waddr = 5'(i); lu_wdata = 32'h100 + 32'(i);
            tick();
            chk("fill_count", fifo_count, 32'(i));
        end
        chk("full_ready", lu_ready, 0);
        lu_waddr = 5'd5; lu_wdata = 32'h105;
        tick();
        chk("held_count", fifo_count, 4);
        chk("held_pipe_waddr", waddr, 20);
        pipe_we = 1'b0;
        chk("full_ready_pop_cycle", lu_ready, 0);
        tick();
        chk("drain1_waddr", waddr, 1);
        chk("drain1_wdata", wdata, 32'h101);
        chk("drain1_count", fifo_count, 3);
        chk("drain1_ready", lu_ready, 1);
        tick();
        lu_valid = 1'b0;
        chk("drain2_waddr", waddr, 2);
        chk("pushpop_count", fifo_count, 3);
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk("drain_we", we, 1);
            chk("drain_waddr", waddr, 32'(k));
            chk("drain_wdata", wdata, 32'h100 + 32'(k));
        end
        chk("drain_end_count", fifo_count, 0);
        tick();
        chk("drain_end_we", we, 0);

        // Scoreboard set/clear
        iss_valid = 1'b1; iss_waddr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd6;
        chk("sb_before", busy1, 0);
        tick();
        iss_valid = 1'b0;
        chk("sb_set", busy1, 1);
        chk("sb_other", busy2, 0);
        raddr2 = 5'd7;
        tick();
        chk("sb_hold", busy2, 1);
        pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'd77;
        tick();
        pipe_we = 1'b0;
        chk("sb_clr_we", we, 1);
        chk("sb_clr_waddr", waddr, 7);
        chk("sb_clr_busy1", busy1, 0);
        iss_valid = 1'b1; pipe_we = 1'b1;
        tick();
        iss_valid = 1'b0; pipe_we = 1'b0;
        chk("sb_setwins_we", we, 1);
        chk("sb_setwins_busy1", busy1, 1);
        pipe_we = 1'b1;
        tick();
        pipe_we = 1'b0;
        chk("sb_clr2_busy1", busy1, 0);

        // Register 0 is never written or reserved
        tick();
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hFFFF;
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hFFFF;
        iss_valid = 1'b1; iss_waddr = 5'd0; raddr1 = 5'd0;
        chk("zero_ready", lu_ready, 1);
        tick();
        pipe_we = 1'b0; lu_valid = 1'b0; iss_valid = 1'b0;
        chk("zero_we", we, 0);
        chk("zero_count", fifo_count, 0);
        chk("zero_busy", busy1, 0);

        // Pipe write to $0 does not block a pop
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h9;
        tick();
        lu_valid = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h5555;
        chk("z0_queued", fifo_count, 1);
        chk("z0_nobypass", we, 0);
        tick();
        pipe_we = 1'b0;
        chk("z0_pop_we", we, 1);
        chk("z0_pop_waddr", waddr, 9);
        chk("z0_pop_wdata", wdata, 32'h9);

        // Asynchronous reset mid-operation
        pipe_we = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'd20;
        iss_valid = 1'b1; iss_waddr = 5'd4; raddr1 = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            lu_valid = 1'b1; lu_waddr = 5'(i); lu_wdata = 32'(i);
            tick();
            iss_valid = 1'b0;
        end
        lu_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_busy", busy1, 1);
        pipe_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_we", we, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wdata", wdata, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ready", lu_ready, 1);
        chk("arst_busy", busy1, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_we", we, 0);
            chk("post_rst_count", fifo_count, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
